// File: rtl/gate_apply_unit.sv
// gate_apply_unit
//   Fetches one 2x2 complex gate matrix from the gate matrix table by index,
//   then streams amplitude pairs through a two-stage complex matrix-vector
//   pipeline (stage 1: products, stage 2: sum, round, shift, saturate/wrap).
//
// Ports
//   clk, reset        single clock, synchronous active-high reset
//   gate, start       gate index and one-cycle command (honoured in IDLE only)
//   busy, op_done     not-idle flag, one-cycle completion pulse
//   tbl_gate          latched gate index presented to the table
//   tbl_ready         one-cycle request pulse to the table
//   tbl_done          table idle/complete flag (high when idle)
//   tbl_result        eight coefficients [row][col][imag]
//   in_*              amplitude pair stream in (in_ready high only in RUN)
//   out_*             result pair stream out (no backpressure)
//
// Build option
//   GATE_APPLY_SAT_EN  when defined, results clamp to the W-bit signed range;
//                      otherwise results wrap to the low W bits.

module gate_apply_unit #(
    parameter int W    = 19,
    parameter int FRAC = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [4:0]          gate,
    input  logic                start,
    output logic                busy,
    output logic                op_done,
    output logic [4:0]          tbl_gate,
    output logic                tbl_ready,
    input  logic                tbl_done,
    input  logic signed [W-1:0] tbl_result [0:1][0:1][0:1],
    input  logic                in_valid,
    input  logic                in_last,
    input  logic signed [W-1:0] in_a_re,
    input  logic signed [W-1:0] in_a_im,
    input  logic signed [W-1:0] in_b_re,
    input  logic signed [W-1:0] in_b_im,
    output logic                in_ready,
    output logic                out_valid,
    output logic signed [W-1:0] out_a_re,
    output logic signed [W-1:0] out_a_im,
    output logic signed [W-1:0] out_b_re,
    output logic signed [W-1:0] out_b_im
);

    // state     | meaning
    // ----------+-----------------------------------------------------------
    // IDLE      | waiting for start
    // REQ       | tbl_ready pulse to the table
    // WAIT_LOW  | waiting for the table to drop tbl_done (request accepted)
    // WAIT_HIGH | waiting for tbl_done to rise; matrix latched on that cycle
    // RUN       | accepting amplitude pairs until in_last
    // DRAIN     | letting the pipeline empty, then op_done
    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_REQ       = 3'd1,
        S_WAIT_LOW  = 3'd2,
        S_WAIT_HIGH = 3'd3,
        S_RUN       = 3'd4,
        S_DRAIN     = 3'd5
    } state_t;

    localparam int PW = 2 * W;
    localparam int AW = 2 * W + 2;
    localparam logic signed [AW-1:0] RND = AW'(1) << (FRAC - 1);
`ifdef GATE_APPLY_SAT_EN
    localparam logic signed [AW-1:0] SAT_MAX = AW'((1 << (W - 1)) - 1);
    localparam logic signed [AW-1:0] SAT_MIN = ~SAT_MAX;
`endif

    state_t                 state_q, state_d;
    logic [4:0]             gate_q, gate_d;
    logic                   op_done_q, op_done_d;
    logic signed [W-1:0]    m_q [0:1][0:1][0:1];
    logic signed [W-1:0]    m_d [0:1][0:1][0:1];
    // p[row][0=re,1=im][term]; re sum is t0 - t1 + t2 - t3, im sum is all plus
    logic signed [PW-1:0]   p_q [0:1][0:1][0:3];
    logic signed [PW-1:0]   p_d [0:1][0:1][0:3];
    logic                   s1_valid_q, s1_valid_d;
    logic                   out_valid_q, out_valid_d;
    logic signed [W-1:0]    res_q [0:1][0:1];
    logic signed [W-1:0]    res_d [0:1][0:1];
    logic                   accept;

    function automatic logic signed [W-1:0] finish(input logic signed [AW-1:0] acc);
`ifdef GATE_APPLY_SAT_EN
        logic signed [AW-1:0] sh;
        sh = (acc + RND) >>> FRAC;
        if (sh > SAT_MAX)
            finish = SAT_MAX[W-1:0];
        else if (sh < SAT_MIN)
            finish = SAT_MIN[W-1:0];
        else
            finish = sh[W-1:0];
`else
        finish = W'((acc + RND) >>> FRAC);
`endif
    endfunction

    // state register and all datapath flops
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            gate_q      <= '0;
            op_done_q   <= 1'b0;
            m_q         <= '{default: '0};
            p_q         <= '{default: '0};
            s1_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
            res_q       <= '{default: '0};
        end else begin
            state_q     <= state_d;
            gate_q      <= gate_d;
            op_done_q   <= op_done_d;
            m_q         <= m_d;
            p_q         <= p_d;
            s1_valid_q  <= s1_valid_d;
            out_valid_q <= out_valid_d;
            res_q       <= res_d;
        end
    end

    // next-state
    always_comb begin
        state_d   = state_q;
        gate_d    = gate_q;
        m_d       = m_q;
        op_done_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    gate_d  = gate;
                    state_d = S_REQ;
                end
            end
            S_REQ:       state_d = S_WAIT_LOW;
            // tbl_done is already high before the request, so a high level
            // only counts as completion after it has been seen low.
            S_WAIT_LOW: begin
                if (!tbl_done)
                    state_d = S_WAIT_HIGH;
            end
            S_WAIT_HIGH: begin
                if (tbl_done) begin
                    m_d     = tbl_result;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (in_valid && in_last)
                    state_d = S_DRAIN;
            end
            // Once stage 1 is empty, stage 2 empties on this same edge.
            S_DRAIN: begin
                if (!s1_valid_q) begin
                    op_done_d = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            default:     state_d = S_IDLE;
        endcase
    end

    // outputs
    always_comb begin
        busy      = (state_q != S_IDLE);
        tbl_ready = (state_q == S_REQ);
        in_ready  = (state_q == S_RUN);
    end

    // two-stage complex multiply-accumulate
    always_comb begin
        logic signed [W-1:0] x_re [0:1];
        logic signed [W-1:0] x_im [0:1];
        x_re[0] = in_a_re;
        x_im[0] = in_a_im;
        x_re[1] = in_b_re;
        x_im[1] = in_b_im;

        accept     = in_ready && in_valid;
        s1_valid_d = accept;
        p_d        = p_q;
        if (accept) begin
            for (int r = 0; r < 2; r++) begin
                for (int c = 0; c < 2; c++) begin
                    p_d[r][0][2*c]   = PW'(m_q[r][c][0]) * PW'(x_re[c]);
                    p_d[r][0][2*c+1] = PW'(m_q[r][c][1]) * PW'(x_im[c]);
                    p_d[r][1][2*c]   = PW'(m_q[r][c][0]) * PW'(x_im[c]);
                    p_d[r][1][2*c+1] = PW'(m_q[r][c][1]) * PW'(x_re[c]);
                end
            end
        end

        out_valid_d = s1_valid_q;
        res_d       = res_q;
        if (s1_valid_q) begin
            for (int r = 0; r < 2; r++) begin
                res_d[r][0] = finish(AW'(p_q[r][0][0]) - AW'(p_q[r][0][1])
                                   + AW'(p_q[r][0][2]) - AW'(p_q[r][0][3]));
                res_d[r][1] = finish(AW'(p_q[r][1][0]) + AW'(p_q[r][1][1])
                                   + AW'(p_q[r][1][2]) + AW'(p_q[r][1][3]));
            end
        end
    end

    assign op_done   = op_done_q;
    assign tbl_gate  = gate_q;
    assign out_valid = out_valid_q;
    assign out_a_re  = res_q[0][0];
    assign out_a_im  = res_q[0][1];
    assign out_b_re  = res_q[1][0];
    assign out_b_im  = res_q[1][1];

endmodule

// File: tb/tb_gate_apply_unit.sv
module tb_gate_apply_unit;

    logic                clk = 1'b0;
    logic                reset;
    logic [4:0]          gate;
    logic                start;
    logic                busy;
    logic                op_done;
    logic [4:0]          tbl_gate;
    logic                tbl_ready;
    logic                tbl_done;
    logic signed [18:0]  tbl_result [0:1][0:1][0:1];
    logic                in_valid;
    logic                in_last;
    logic signed [18:0]  in_a_re, in_a_im, in_b_re, in_b_im;
    logic                in_ready;
    logic                out_valid;
    logic signed [18:0]  out_a_re, out_a_im, out_b_re, out_b_im;

    logic signed [18:0]  mat [0:1][0:1][0:1];
    int checks   = 0;
    int failures = 0;

    int pa_re [4] = '{11, -22000, 131071, -262144};
    int pa_im [4] = '{5, 0, -1, 77};
    int pb_re [4] = '{-300, 65536, 2, 0};
    int pb_im [4] = '{40000, -9, 3, -123456};

`ifdef GATE_APPLY_SAT_EN
    localparam int SAT_EXP = 262143;
`else
    localparam int SAT_EXP = -124288;
`endif

    gate_apply_unit #(.W(19), .FRAC(16)) dut (
        .clk(clk), .reset(reset), .gate(gate), .start(start),
        .busy(busy), .op_done(op_done), .tbl_gate(tbl_gate),
        .tbl_ready(tbl_ready), .tbl_done(tbl_done), .tbl_result(tbl_result),
        .in_valid(in_valid), .in_last(in_last),
        .in_a_re(in_a_re), .in_a_im(in_a_im), .in_b_re(in_b_re), .in_b_im(in_b_im),
        .in_ready(in_ready), .out_valid(out_valid),
        .out_a_re(out_a_re), .out_a_im(out_a_im), .out_b_re(out_b_re), .out_b_im(out_b_im)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_pair(input int are, input int aim, input int bre, input int bim,
                              input logic last);
        in_valid = 1'b1;
        in_last  = last;
        in_a_re  = 19'(are);
        in_a_im  = 19'(aim);
        in_b_re  = 19'(bre);
        in_b_im  = 19'(bim);
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_a_re  = '0;
        in_a_im  = '0;
        in_b_re  = '0;
        in_b_im  = '0;
    endtask

    // Start an operation and play the table side; returns in the first RUN cycle.
    task automatic do_fetch(input logic [4:0] g, input int extra_high, input int low_cycles);
        gate  = g;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("req_busy", busy, 1);
        chk("req_tbl_ready", tbl_ready, 1);
        chk("req_tbl_gate", tbl_gate, g);
        step();
        chk("wl_tbl_ready", tbl_ready, 0);
        for (int i = 0; i < extra_high; i++) begin
            step();
            chk("wl_hi_in_ready", in_ready, 0);
            chk("wl_hi_tbl_ready", tbl_ready, 0);
        end
        tbl_done = 1'b0;
        for (int i = 0; i < low_cycles; i++) begin
            step();
            chk("wh_in_ready", in_ready, 0);
            chk("wh_tbl_ready", tbl_ready, 0);
        end
        tbl_result = mat;
        tbl_done   = 1'b1;
        step();
        chk("run_in_ready", in_ready, 1);
        tbl_result = '{default: 19'sd12345};
    endtask

    initial begin
        reset      = 1'b1;
        gate       = '0;
        start      = 1'b0;
        tbl_done   = 1'b1;
        tbl_result = '{default: 19'sd12345};
        idle_inputs();
        step();
        step();
        reset = 1'b0;

        // reset values
        chk("rst_busy", busy, 0);
        chk("rst_op_done", op_done, 0);
        chk("rst_tbl_ready", tbl_ready, 0);
        chk("rst_tbl_gate", tbl_gate, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_a_re", out_a_re, 0);
        chk("rst_out_b_im", out_b_im, 0);

        // Hadamard, single pair
        mat = '{default: '0};
        mat[0][0][0] = 19'sd46341;
        mat[0][1][0] = 19'sd46341;
        mat[1][0][0] = 19'sd46341;
        mat[1][1][0] = -19'sd46341;
        do_fetch(5'd2, 0, 2);
        drive_pair(65536, 0, 0, 0, 1'b1);
        step();
        idle_inputs();
        chk("h_k1_in_ready", in_ready, 0);
        chk("h_k1_out_valid", out_valid, 0);
        step();
        chk("h_out_valid", out_valid, 1);
        chk("h_out_a_re", out_a_re, 46341);
        chk("h_out_a_im", out_a_im, 0);
        chk("h_out_b_re", out_b_re, 46341);
        chk("h_out_b_im", out_b_im, 0);
        chk("h_k2_op_done", op_done, 0);
        step();
        chk("h_op_done", op_done, 1);
        chk("h_busy", busy, 0);
        chk("h_k3_out_valid", out_valid, 0);
        step();
        chk("h_op_done_pulse", op_done, 0);

        // Pauli-X with a slow table, start ignored in RUN, 4 back-to-back pairs
        mat = '{default: '0};
        mat[0][1][0] = 19'sd65536;
        mat[1][0][0] = 19'sd65536;
        do_fetch(5'd3, 3, 8);
        gate  = 5'd9;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("x_ign_tbl_gate", tbl_gate, 3);
        chk("x_ign_tbl_ready", tbl_ready, 0);
        chk("x_ign_in_ready", in_ready, 1);
        for (int c = 0; c < 7; c++) begin
            if (c < 4)
                drive_pair(pa_re[c], pa_im[c], pb_re[c], pb_im[c], c == 3);
            else
                idle_inputs();
            step();
            chk("x_out_valid", out_valid, (c >= 1 && c <= 4) ? 1 : 0);
            chk("x_op_done", op_done, (c == 5) ? 1 : 0);
            chk("x_tbl_ready", tbl_ready, 0);
            if (c >= 1 && c <= 4) begin
                chk("x_out_a_re", out_a_re, pb_re[c-1]);
                chk("x_out_a_im", out_a_im, pb_im[c-1]);
                chk("x_out_b_re", out_b_re, pa_re[c-1]);
                chk("x_out_b_im", out_b_im, pa_im[c-1]);
            end
        end
        chk("x_busy_end", busy, 0);

        // saturation / wrap, same gate index re-fetched
        mat = '{default: '0};
        mat[0][0][0] = 19'sd65536;
        mat[0][1][0] = 19'sd65536;
        do_fetch(5'd3, 0, 1);
        drive_pair(200000, 0, 200000, 0, 1'b1);
        step();
        idle_inputs();
        step();
        chk("s_out_valid", out_valid, 1);
        chk("s_out_a_re", out_a_re, SAT_EXP);
        chk("s_out_a_im", out_a_im, 0);
        chk("s_out_b_re", out_b_re, 0);
        step();
        chk("s_op_done", op_done, 1);

        // reset one cycle after a pair is accepted
        mat = '{default: '0};
        mat[0][0][0] = 19'sd46341;
        mat[0][1][0] = 19'sd46341;
        mat[1][0][0] = 19'sd46341;
        mat[1][1][0] = -19'sd46341;
        do_fetch(5'd5, 1, 3);
        drive_pair(0, 65536, 65536, 0, 1'b0);
        step();
        idle_inputs();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("r_out_valid", out_valid, 0);
        chk("r_busy", busy, 0);
        chk("r_in_ready", in_ready, 0);
        chk("r_tbl_gate", tbl_gate, 0);
        chk("r_op_done", op_done, 0);
        step();
        chk("r_out_valid2", out_valid, 0);
        chk("r_busy2", busy, 0);
        do_fetch(5'd6, 0, 2);
        drive_pair(0, 65536, 65536, 0, 1'b1);
        step();
        idle_inputs();
        step();
        chk("r2_out_valid", out_valid, 1);
        chk("r2_out_a_re", out_a_re, 46341);
        chk("r2_out_a_im", out_a_im, 46341);
        chk("r2_out_b_re", out_b_re, -46341);
        chk("r2_out_b_im", out_b_im, 46341);
        step();
        chk("r2_op_done", op_done, 1);
        chk("r2_busy", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
